tick_scheduler: RTL

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Programmable tick generator with round-robin slot grants.
// A divisor offered while running waits and takes effect on a frame boundary.
module tick_scheduler #(
    parameter int DIV_W   = 24,
    parameter int DEF_DIV = 27000,
    parameter int N_SLOTS = 4,
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               cfg_valid,
    input  logic [DIV_W-1:0]   cfg_div,
    output logic               cfg_ready,
    output logic               tick,
    output logic [SLOT_W-1:0]  slot,
    output logic [N_SLOTS-1:0] slot_en,
    output logic               frame
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(2);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEF_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_SLOTS - 1);

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  pend_q, pend_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    logic             active;
    logic             wrap;
    logic             last_slot;
    logic             cfg_take;
    logic [DIV_W-1:0] cfg_clamped;

    assign active      = (state_q != ST_IDLE);
    assign wrap        = active && (cnt_q == div_q - DIV_W'(1));
    assign last_slot   = (slot_q == SLOT_LAST);
    assign cfg_ready   = (state_q != ST_PEND);
    assign cfg_take    = cfg_valid && cfg_ready;
    assign cfg_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

    assign tick  = wrap;
    assign frame = wrap && last_slot;
    assign slot  = slot_q;

    always_comb begin
        slot_en = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_en[i] = active && (slot_q == SLOT_W'(i));
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no
        // branch below can leave a signal unassigned and infer a latch.
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        slot_d  = slot_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_take) div_d = cfg_clamped;
                if (run) state_d = ST_RUN;
            end

            ST_RUN, ST_PEND: begin
                if (!run) begin
                    // Leaving: counters restart, any waiting divisor becomes current.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    slot_d  = '0;
                    pend_d  = '0;
                    if (state_q == ST_PEND) div_d = pend_q;
                    if (cfg_take) div_d = cfg_clamped;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
                    if (wrap) slot_d = last_slot ? '0 : slot_q + SLOT_W'(1);
                    // Only a frame seen while already pending applies the new divisor,
                    // so an offer landing on a frame cycle waits one more frame.
                    if ((state_q == ST_PEND) && frame) begin
                        div_d   = pend_q;
                        state_d = ST_RUN;
                    end
                    if (cfg_take) begin
                        pend_d  = cfg_clamped;
                        state_d = ST_PEND;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples the
        // pre-edge values; reset is synchronous and overrides run and cfg_valid.
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_RST;
            cnt_q   <= '0;
            pend_q  <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
        end
    end

    // Structural invariants of the outputs.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(slot_en));
    a_frame_in_tick: assert property (@(posedge clk) disable iff (rst) frame |-> tick);
    a_slot_range: assert property (@(posedge clk) disable iff (rst) slot_q <= SLOT_LAST);

endmodule
